// File: rtl/sysbus_line_fetch_pkg.sv
// Shared Sysbus definitions for the line-fill engine: tag type codes,
// FSM state encoding and the line-alignment helper.
package sysbus_pkg;

    localparam logic [3:0] REQ_READ      = 4'h1;
    localparam logic [3:0] REQ_WRITE     = 4'h2;
    localparam logic [3:0] REQ_MASK_TYPE = 4'hf;

    // Widest address the alignment helper handles; callers cast in and out.
    localparam int unsigned ALIGN_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } fetch_state_e;

    // Clears the byte-offset-within-line bits; beats and data_width are powers of two.
    function automatic logic [ALIGN_W-1:0] line_align(
        input logic [ALIGN_W-1:0] addr,
        input int unsigned        beats,
        input int unsigned        data_width
    );
        logic [ALIGN_W-1:0] line_bytes;
        line_bytes = ALIGN_W'(beats * data_width / 8);
        return addr & ~(line_bytes - ALIGN_W'(1));
    endfunction

endpackage

// File: rtl/sysbus_line_fetch_if.sv
// Client fill handshake plus Sysbus request/response channels of the
// line-fill engine. master = engine side, slave = client/uncore side.
interface sysbus_line_fetch_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 13,
    parameter int unsigned BEATS      = 8
);
    logic                        fill_valid;
    logic [DATA_WIDTH-1:0]       fill_addr;
    logic                        fill_ready;

    logic                        line_valid;
    logic [DATA_WIDTH-1:0]       line_addr;
    logic [DATA_WIDTH*BEATS-1:0] line_data;
    logic                        line_ready;

    logic [DATA_WIDTH-1:0]       req;
    logic [TAG_WIDTH-1:0]        reqtag;
    logic                        reqcyc;
    logic                        reqack;

    logic [DATA_WIDTH-1:0]       resp;
    logic [TAG_WIDTH-1:0]        resptag;
    logic                        respcyc;
    logic                        respack;

    modport master (
        input  fill_valid, fill_addr, line_ready, reqack, resp, resptag, respcyc,
        output fill_ready, line_valid, line_addr, line_data, req, reqtag, reqcyc, respack
    );

    modport slave (
        output fill_valid, fill_addr, line_ready, reqack, resp, resptag, respcyc,
        input  fill_ready, line_valid, line_addr, line_data, req, reqtag, reqcyc, respack
    );

endinterface

// File: rtl/sysbus_line_fetch_line_assembler.sv
// Beat counter and slot register that collects BEATS response beats into
// one line; full marks the write that completes the line.
module line_assembler #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BEATS      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        we,
    input  logic [DATA_WIDTH-1:0]       beat,
    output logic                        full,
    output logic [DATA_WIDTH*BEATS-1:0] line
);

    localparam int unsigned CW = $clog2(BEATS);

    logic [CW-1:0]               cnt;
    logic [DATA_WIDTH*BEATS-1:0] slots;

    assign full = we && (cnt == CW'(BEATS - 1));
    assign line = slots;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            slots <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (we) begin
            slots[cnt*DATA_WIDTH +: DATA_WIDTH] <= beat;
            cnt <= full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sysbus_line_fetch.sv
// Read-miss line-fill engine: one tagged Sysbus read per client request,
// collects BEATS matching-tag response beats and hands back the line.
module sysbus_line_fetch
    import sysbus_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           TAG_WIDTH  = 13,
    parameter int unsigned           BEATS      = 8,
    parameter logic [TAG_WIDTH-5:0]  TAG_ID     = (TAG_WIDTH-4)'(1)
) (
    input  logic                 clk,
    input  logic                 reset,
    sysbus_line_fetch_if.master  bus
);

    localparam logic [TAG_WIDTH-1:0] ISSUE_TAG = {REQ_READ, TAG_ID};

    fetch_state_e state, state_nx;

    logic                        fill_ready_c;
    logic                        reqcyc_c;
    logic                        respack_c;
    logic                        line_valid_c;
    logic                        accept_fill;
    logic                        line_full;
    logic [DATA_WIDTH-1:0]       aligned;
    logic [DATA_WIDTH-1:0]       req_q;
    logic [DATA_WIDTH-1:0]       line_addr_q;
    logic [TAG_WIDTH-1:0]        reqtag_q;
    logic [DATA_WIDTH*BEATS-1:0] line_q;

    assign aligned = DATA_WIDTH'(line_align(ALIGN_W'(bus.fill_addr), BEATS, DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        fill_ready_c = 1'b0;
        reqcyc_c     = 1'b0;
        respack_c    = 1'b0;
        line_valid_c = 1'b0;
        accept_fill  = 1'b0;
        unique case (state)
            IDLE: begin
                fill_ready_c = 1'b1;
                if (bus.fill_valid) begin
                    accept_fill = 1'b1;
                    state_nx    = REQ;
                end
            end
            REQ: begin
                reqcyc_c = 1'b1;
                if (bus.reqack) state_nx = RESP;
            end
            RESP: begin
                // Foreign-tag beats belong to another requester and are left unacknowledged.
                respack_c = bus.respcyc && (bus.resptag == ISSUE_TAG);
                if (line_full) state_nx = DONE;
            end
            DONE: begin
                line_valid_c = 1'b1;
                if (bus.line_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q       <= '0;
            line_addr_q <= '0;
            reqtag_q    <= '0;
        end else if (accept_fill) begin
            req_q       <= aligned;
            line_addr_q <= aligned;
            reqtag_q    <= ISSUE_TAG;
        end
    end

    line_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS)
    ) u_asm (
        .clk   (clk),
        .rst_n (reset),
        .clr   (accept_fill),
        .we    (respack_c),
        .beat  (bus.resp),
        .full  (line_full),
        .line  (line_q)
    );

    assign bus.fill_ready = fill_ready_c;
    assign bus.reqcyc     = reqcyc_c;
    assign bus.respack    = respack_c;
    assign bus.line_valid = line_valid_c;
    assign bus.req        = req_q;
    assign bus.reqtag     = reqtag_q;
    assign bus.line_addr  = line_addr_q;
    assign bus.line_data  = line_q;

endmodule

// File: tb/tb_sysbus_line_fetch.sv
// Bench for sysbus_line_fetch: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model.
module tb_sysbus_line_fetch;

    localparam logic [12:0] TAG = 13'h0201;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sysbus_line_fetch_if #(.DATA_WIDTH(64), .TAG_WIDTH(13), .BEATS(8)) bus ();

    sysbus_line_fetch #(
        .DATA_WIDTH (64),
        .TAG_WIDTH  (13),
        .BEATS      (8),
        .TAG_ID     (9'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Transaction-level model: progress through one fill as flags plus a beat queue.
    logic        busy = 1'b0;
    logic        acked = 1'b0;
    logic [63:0] m_addr = '0;
    logic [12:0] m_tag = '0;
    logic [63:0] got[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                busy = 1'b0;
                acked = 1'b0;
                got.delete();
                m_addr = '0;
                m_tag = '0;
            end else if (!busy) begin
                if (bus.fill_valid) begin
                    busy = 1'b1;
                    acked = 1'b0;
                    got.delete();
                    m_addr = (bus.fill_addr / 64) * 64;
                    m_tag = TAG;
                end
            end else if (!acked) begin
                if (bus.reqack) acked = 1'b1;
            end else if (got.size() < 8) begin
                if (bus.respcyc && bus.resptag == TAG) got.push_back(bus.resp);
            end else if (bus.line_ready) begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        logic [511:0] exp_line;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk1("fill_ready", bus.fill_ready, !busy);
            chk1("reqcyc", bus.reqcyc, busy && !acked);
            chk1("respack", bus.respack,
                 busy && acked && (got.size() < 8) && bus.respcyc && (bus.resptag == TAG));
            chk1("line_valid", bus.line_valid, busy && (got.size() == 8));
            chk64("req", bus.req, m_addr);
            chk64("line_addr", bus.line_addr, m_addr);
            chk64("reqtag", 64'(bus.reqtag), 64'(m_tag));
            if (busy && got.size() == 8) begin
                exp_line = '0;
                for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = got[k];
                chk_line("line_data", bus.line_data, exp_line);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] addr);
        int guard = 0;
        while (bus.fill_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk1("fill_ready_wait", bus.fill_ready, 1'b1);
        bus.fill_valid = 1'b1;
        bus.fill_addr  = addr;
        tick();
        bus.fill_valid = 1'b0;
    endtask

    // Holds reqack low for dly cycles, optionally offering a matching beat meanwhile.
    task automatic ack(input int dly, input bit early);
        for (int i = 0; i < dly; i++) begin
            bus.respcyc = early;
            bus.resptag = TAG;
            bus.resp    = 64'hdead_beef_0000_0000 + 64'(i);
            tick();
        end
        bus.respcyc = 1'b0;
        bus.reqack  = 1'b1;
        tick();
        bus.reqack  = 1'b0;
    endtask

    task automatic beats(input logic [63:0] base, input bit gappy);
        int k = 0;
        int guard = 0;
        int r;
        while (k < 8 && guard < 100) begin
            r = int'($urandom % 4);
            if (gappy && r == 0) begin
                bus.respcyc = 1'b0;
            end else if (gappy && r == 1) begin
                bus.respcyc = 1'b1;
                bus.resptag = 13'h0005;
                bus.resp    = 64'h0bad_0bad_0bad_0bad;
            end else begin
                bus.respcyc = 1'b1;
                bus.resptag = TAG;
                bus.resp    = base * 64'(k + 1);
                k++;
            end
            tick();
            guard++;
        end
        bus.respcyc = 1'b0;
        chk64("beats_sent", 64'(k), 64'd8);
    endtask

    task automatic check_line(input logic [63:0] base);
        chk1("line_valid_after_last", bus.line_valid, 1'b1);
        for (int k = 0; k < 8; k++)
            chk64($sformatf("beat%0d", k), bus.line_data[k*64 +: 64], base * 64'(k + 1));
    endtask

    // Stalls the line for hold cycles, poking a fill request midway that must be ignored.
    task automatic take(input int hold);
        bus.line_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.fill_valid = (i == hold / 2);
            bus.fill_addr  = 64'h9999_0000;
            tick();
        end
        bus.fill_valid = 1'b0;
        bus.line_ready = 1'b1;
        tick();
        bus.line_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        bus.fill_valid = 1'b0;
        bus.fill_addr  = '0;
        bus.line_ready = 1'b0;
        bus.reqack     = 1'b0;
        bus.resp       = '0;
        bus.resptag    = '0;
        bus.respcyc    = 1'b0;
        tick();
        tick();
        chk1("rst_fill_ready", bus.fill_ready, 1'b1);
        chk1("rst_reqcyc", bus.reqcyc, 1'b0);
        chk1("rst_line_valid", bus.line_valid, 1'b0);
        chk64("rst_req", bus.req, 64'h0);
        chk64("rst_reqtag", 64'(bus.reqtag), 64'h0);
        chk_line("rst_line_data", bus.line_data, '0);
        reset = 1'b1;
        tick();

        // Basic fill
        issue(64'h1000_0047);
        chk1("basic_reqcyc", bus.reqcyc, 1'b1);
        chk1("basic_fill_ready", bus.fill_ready, 1'b0);
        chk64("basic_req", bus.req, 64'h1000_0040);
        chk64("basic_reqtag", 64'(bus.reqtag), 64'h0201);
        ack(1, 1'b0);
        chk1("basic_reqcyc_drop", bus.reqcyc, 1'b0);
        beats(64'h11, 1'b0);
        check_line(64'h11);
        take(0);

        // Gapped and foreign beats
        issue(64'h0000_1234_5678_9abc);
        ack(3, 1'b0);
        beats(64'h1000_0001, 1'b1);
        check_line(64'h1000_0001);
        take(1);

        // Backpressure with an ignored fill pulse
        issue(64'h40);
        ack(0, 1'b0);
        beats(64'h22, 1'b0);
        check_line(64'h22);
        take(5);
        chk64("bp_req_kept", bus.req, 64'h40);

        // Reset mid-RESP
        issue(64'h3000_0010);
        ack(0, 1'b0);
        bus.respcyc = 1'b1;
        bus.resptag = TAG;
        for (int k = 0; k < 3; k++) begin
            bus.resp = 64'h5 * 64'(k + 1);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk1("mid_fill_ready", bus.fill_ready, 1'b1);
        chk1("mid_line_valid", bus.line_valid, 1'b0);
        chk64("mid_req", bus.req, 64'h0);
        chk64("mid_line_addr", bus.line_addr, 64'h0);
        chk_line("mid_line_data", bus.line_data, '0);
        for (int k = 0; k < 4; k++) begin
            bus.resp = 64'h77;
            #1;
            chk1("mid_respack", bus.respack, 1'b0);
            tick();
        end
        bus.respcyc = 1'b0;
        issue(64'h3000_0080);
        ack(0, 1'b0);
        beats(64'h101, 1'b0);
        check_line(64'h101);
        take(0);

        // Early response while in REQ
        issue(64'h4000_0000);
        ack(3, 1'b1);
        beats(64'h33, 1'b0);
        check_line(64'h33);
        take(0);

        // Back-to-back with fill_valid held high
        bus.fill_valid = 1'b1;
        bus.fill_addr  = 64'h2000;
        tick();
        bus.fill_addr  = 64'h2040;
        chk64("b2b_req0", bus.req, 64'h2000);
        ack(0, 1'b0);
        beats(64'h44, 1'b0);
        check_line(64'h44);
        bus.line_ready = 1'b1;
        tick();
        bus.line_ready = 1'b0;
        chk1("b2b_gap_reqcyc", bus.reqcyc, 1'b0);
        chk1("b2b_gap_fill_ready", bus.fill_ready, 1'b1);
        tick();
        bus.fill_valid = 1'b0;
        chk1("b2b_reqcyc1", bus.reqcyc, 1'b1);
        chk64("b2b_req1", bus.req, 64'h2040);
        ack(0, 1'b0);
        beats(64'h55, 1'b0);
        check_line(64'h55);
        take(0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom % 150) != 0;
            bus.fill_valid = ($urandom % 10) < 3;
            bus.fill_addr  = {$urandom, $urandom};
            bus.reqack     = ($urandom % 10) < 3;
            bus.respcyc    = ($urandom % 2) == 1;
            bus.resptag    = (($urandom % 4) != 0) ? TAG : 13'($urandom);
            bus.resp       = {$urandom, $urandom};
            bus.line_ready = ($urandom % 10) < 4;
            tick();
        end
        reset          = 1'b0;
        bus.fill_valid = 1'b0;
        bus.respcyc    = 1'b0;
        bus.reqack     = 1'b0;
        bus.line_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysbus_line_fetch.md
Name: sysbus_line_fetch

Overview:
- Read-miss fill engine between the core's cache/fetch logic and the Sysbus uncore port.
- Accepts one line-fill request from a client and issues a single tagged read request on the Sysbus request channel.
- Collects BEATS response beats carrying the matching tag and returns the assembled line to the client.
- One outstanding request at a time. Multiple clients are served through an external arbiter.

Parameters:
- DATA_WIDTH, 64, Sysbus data/request width (bits).
- TAG_WIDTH, 13, Sysbus tag width.
- BEATS, 8, response beats per line; power of two, ≥2.
- TAG_ID, 9'd1, requester ID placed in the low TAG_WIDTH-4 bits of reqtag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- fill_valid  in  1  client fill request.
- fill_addr  in  DATA_WIDTH  byte address of requested line.
- fill_ready  out  1  engine can accept a request.
- line_valid  out  1  assembled line available.
- line_addr  out  DATA_WIDTH  line-aligned address of returned line.
- line_data  out  DATA_WIDTH*BEATS  line; beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- line_ready  in  1  client consumes line.
- req  out  DATA_WIDTH  Sysbus request address.
- reqtag  out  TAG_WIDTH  Sysbus request tag.
- reqcyc  out  1  Sysbus request valid.
- reqack  in  1  Sysbus request accepted.
- resp  in  DATA_WIDTH  Sysbus response data.
- resptag  in  TAG_WIDTH  Sysbus response tag.
- respcyc  in  1  Sysbus response beat valid.
- respack  out  1  response beat consumed.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset is synchronous and active-low (reset==0 sampled at the rising clk edge resets).
- Reset values:
  - state=IDLE, fill_ready=1, reqcyc=0, respack=0, line_valid=0.
  - req, reqtag, line_addr, line_data = 0; beat counter = 0.
- LINE_BYTES = BEATS*DATA_WIDTH/8. The alignment mask clears the low log2(LINE_BYTES) bits (6 bits at defaults).
- Issued tag: ISSUE_TAG = {REQ_READ (4'h1), TAG_ID}, registered into reqtag.
- FSM states and transitions:
  - IDLE:
    - fill_ready=1.
    - fill_valid && fill_ready at an edge → latch the aligned address into req and line_addr, set reqcyc=1, clear the beat counter, go REQ.
    - fill_ready falls in the same edge.
  - REQ:
    - reqcyc=1; req and reqtag held stable.
    - reqack sampled high → reqcyc=0 at that edge, go RESP.
    - reqack has no timeout.
  - RESP:
    - respack = respcyc && (resptag == ISSUE_TAG), combinational.
    - On each accepted beat, resp is written to slot[counter] and the counter increments.
    - Beats with a mismatched tag get respack=0 and are ignored, with no state change.
    - Accepting the beat with counter==BEATS-1 → counter wraps to 0, line_valid=1 next cycle, go DONE.
  - DONE:
    - line_valid=1; line_data and line_addr are stable.
    - line_ready sampled high → line_valid=0, fill_ready=1, go IDLE.
    - No back-to-back bypass: a new fill is accepted no earlier than the cycle after DONE exits.
- respack is 0 in every state except RESP.
- A response beat with a matching tag arriving while in REQ (before reqack) is not acknowledged.
- Latency, minimum, fill handshake to line_valid: 1 (issue) + 1 (reqack) + BEATS cycles.
- Reset mid-operation (any state): immediate return to reset values.
  - The partial line is discarded.
  - An in-flight Sysbus request is abandoned; subsequent beats are ignored because state=IDLE.
- fill_valid is ignored outside IDLE.

Decomposition:
- Package sysbus_pkg holds:
  - The tag-type constants: REQ_READ=4'h1, REQ_WRITE=4'h2, REQ_MASK_TYPE.
  - The FSM state enum (IDLE, REQ, RESP, DONE).
  - The function line_align(addr, BEATS, DATA_WIDTH).
- One natural sub-module: line_assembler. It holds the beat counter and the BEATS×DATA_WIDTH shift/slot register, with write enable, beat in, clear, and a full flag out.

Test Plan:
- Basic fill:
  - Stimulus: fill_addr=0x1000_0047; reqack 2 cycles after reqcyc; 8 beats 0x11..0x88 with tag {1,TAG_ID} on consecutive cycles.
  - Required: req=0x1000_0040, reqtag=0x0201 (TAG_ID=1), line_data beat0=0x11 through beat7=0x88, line_valid exactly 1 cycle after the last beat.
- Gapped and foreign beats:
  - Stimulus: respcyc toggles 1/0; a beat with tag 0x0005 is interleaved.
  - Required: respack=0 on the foreign beat; line holds only the 8 matching beats, in order.
- Backpressure:
  - Stimulus: hold line_ready=0 for 5 cycles after line_valid.
  - Required: line_valid and line_data stable; fill_ready=0; a fill_valid pulse during this time is not accepted.
- Reset mid-RESP:
  - Stimulus: reset=0 after 3 beats.
  - Required: next cycle all outputs at reset values; the remaining 5 beats get respack=0; the next fill assembles correctly from beat 0.
- Early response:
  - Stimulus: matching-tag beat while still in REQ.
  - Required: respack=0; the beat count is unaffected.
- Back-to-back fills:
  - Stimulus: fill_valid held high across two fills (0x2000, 0x2040).
  - Required: two distinct requests; the second reqcyc rises no earlier than the cycle after line_ready handshake.
